srl_fifo_af: RTL and testbench



---
 rtl/srl_fifo_af.sv | 117 +++++++++++
 tb/tb_srl_fifo_af.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo_af.sv
// srl_fifo_af: shift-register FIFO with full/empty handshakes, occupancy count, almost-full
// flag and an optional registered first-word-fall-through output stage.
module srl_fifo_af #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] DepthC   = CntW'(DEPTH);
  // Almost-full once free entries (DEPTH - count) drop to AF_MARGIN or below.
  localparam logic [CntW-1:0] AfLevelC = CntW'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] srl_dout;
  logic                  push, pop;
  logic                  srl_we, srl_re;

  assign push   = if_write & if_write_ce & if_full_n;
  assign pop    = if_read & if_read_ce & if_empty_n;
  // Requests coinciding with reset must not disturb the storage either.
  assign srl_we = push & ~reset;

  // Oldest entry sits at the top of the occupied region.
  assign rd_addr  = (count_q != '0) ? ADDR_WIDTH'(count_q - 1'b1) : '0;
  assign srl_dout = srl_q[rd_addr];

  // Shift storage: new word enters index 0, everything else moves up; not reset.
  always_ff @(posedge clk) begin
    if (srl_we) begin
      srl_q[0] <= if_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  // Occupancy of the shift storage: write and read in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    if (srl_we && !srl_re) begin
      count_d = count_q + 1'b1;
    end else if (srl_re && !srl_we) begin
      count_d = count_q - 1'b1;
    end
  end

  // SRL occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign if_full_n        = (count_q != DepthC);
  assign if_almost_full_n = (count_q < AfLevelC);

  if (OUT_REG == 0) begin : g_direct
    assign srl_re            = pop;
    assign if_dout           = srl_dout;
    assign if_empty_n        = (count_q != '0);
    assign if_num_data_valid = count_q;
  end else begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    // Refill the output stage whenever it is empty or being drained this cycle.
    assign srl_re = (count_q != '0) & (~valid_q | pop);

    // Next state of the output holding register.
    always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      if (srl_re) begin
        dout_d  = srl_dout;
        valid_d = 1'b1;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end

    // Output holding register and its valid bit.
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign if_dout           = dout_q;
    assign if_empty_n        = valid_q;
    assign if_num_data_valid = count_q + CntW'(valid_q);
  end

endmodule

// File: tb/tb_srl_fifo_af.sv
// Bench for srl_fifo_af: one direct-read and one registered-output instance, table vectors,
// hand-written corner sequences and a randomized run against a queue-based model.
module tb_srl_fifo_af;

  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int DEP = 4;
  localparam int AFM = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          w0, wce0, r0, rce0, full0, af0, empty0;
  logic [DW-1:0] din0, dout0;
  logic [AW:0]   cnt0;
  logic          w1, wce1, r1, rce1, full1, af1, empty1;
  logic [DW-1:0] din1, dout1;
  logic [AW:0]   cnt1;

  always #5 clk = ~clk;

  srl_fifo_af #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .AF_MARGIN(AFM), .OUT_REG(0)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .if_write_ce(wce0), .if_write(w0), .if_din(din0),
    .if_full_n(full0), .if_almost_full_n(af0),
    .if_read_ce(rce0), .if_read(r0), .if_dout(dout0),
    .if_empty_n(empty0), .if_num_data_valid(cnt0)
  );

  srl_fifo_af #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .AF_MARGIN(AFM), .OUT_REG(1)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .if_write_ce(wce1), .if_write(w1), .if_din(din1),
    .if_full_n(full1), .if_almost_full_n(af1),
    .if_read_ce(rce1), .if_read(r1), .if_dout(dout1),
    .if_empty_n(empty1), .if_num_data_valid(cnt1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0 = 0; wce0 = 1; r0 = 0; rce0 = 1; din0 = '0;
    w1 = 0; wce1 = 1; r1 = 0; rce1 = 1; din1 = '0;
  endtask

  task automatic drive_both(input bit w, input bit r, input logic [DW-1:0] d);
    w0 = w; r0 = r; din0 = d;
    w1 = w; r1 = r; din1 = d;
  endtask

  // Flags of a FIFO whose SRL holds srl words, from the documented rules.
  task automatic chk_flags(input string tag, input bit dut, input int srl);
    if (dut == 0) begin
      chk({tag, " full_n"}, full0, srl != DEP);
      chk({tag, " af_n"}, af0, (DEP - srl) > AFM);
    end else begin
      chk({tag, " full_n"}, full1, srl != DEP);
      chk({tag, " af_n"}, af1, (DEP - srl) > AFM);
    end
  endtask

  typedef struct {
    bit          w, wce, r, rce;
    logic [7:0]  din;
    int          cnt;
    logic [7:0]  dout;
    bit          chk_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w, bit wce, bit r, bit rce, logic [7:0] din, int cnt,
                              logic [7:0] dout, bit cd);
    vec_t v;
    v.w = w; v.wce = wce; v.r = r; v.rce = rce; v.din = din;
    v.cnt = cnt; v.dout = dout; v.chk_dout = cd;
    return v;
  endfunction

  // Reference model state.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            v1;

  initial begin
    int srl, old, pct_w, pct_r;
    bit p0, pp0, p1, pp1;

    // Direct-read vectors: inputs for one edge, then state after that edge.
    vecs.push_back(mk(1, 1, 0, 1, 8'h0A, 1, 8'h0A, 1));
    vecs.push_back(mk(1, 1, 0, 1, 8'h0B, 2, 8'h0A, 1));
    vecs.push_back(mk(1, 1, 0, 1, 8'h0C, 3, 8'h0A, 1));
    vecs.push_back(mk(1, 1, 0, 1, 8'h0D, 4, 8'h0A, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 3, 8'h0B, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 2, 8'h0C, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'h0D, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 1, 1, 8'h11, 1, 8'h11, 1)); // empty: pop rejected
    vecs.push_back(mk(1, 1, 0, 1, 8'h22, 2, 8'h11, 1));
    vecs.push_back(mk(1, 1, 0, 1, 8'h33, 3, 8'h11, 1));
    vecs.push_back(mk(1, 1, 0, 1, 8'h44, 4, 8'h11, 1));
    vecs.push_back(mk(1, 1, 1, 1, 8'h55, 3, 8'h22, 1)); // full: push rejected
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 2, 8'h33, 1));
    vecs.push_back(mk(1, 1, 1, 1, 8'h66, 2, 8'h44, 1));
    vecs.push_back(mk(1, 1, 1, 1, 8'h77, 2, 8'h66, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 1, 8'h77, 1));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h99, 0, 8'h00, 0)); // write_ce low
    vecs.push_back(mk(1, 1, 0, 1, 8'h99, 1, 8'h99, 1));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 1, 8'h99, 1)); // read_ce low
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 8'h00, 0));

    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    chk("rst0 cnt", cnt0, 0);
    chk("rst0 empty_n", empty0, 0);
    chk_flags("rst0", 0, 0);
    chk("rst1 cnt", cnt1, 0);
    chk("rst1 empty_n", empty1, 0);
    chk("rst1 dout", dout1, 0);
    chk_flags("rst1", 1, 0);

    foreach (vecs[i]) begin
      w0 = vecs[i].w; wce0 = vecs[i].wce; r0 = vecs[i].r; rce0 = vecs[i].rce;
      din0 = vecs[i].din;
      tick();
      chk($sformatf("tbl[%0d] cnt", i), cnt0, vecs[i].cnt);
      chk($sformatf("tbl[%0d] empty_n", i), empty0, vecs[i].cnt != 0);
      chk_flags($sformatf("tbl[%0d]", i), 0, vecs[i].cnt);
      if (vecs[i].chk_dout) chk($sformatf("tbl[%0d] dout", i), dout0, vecs[i].dout);
    end
    idle();

    // Registered output: fill to DEPTH+1, first word appears two edges after first push.
    for (int k = 1; k <= 5; k++) begin
      w1 = 1; din1 = DW'(k);
      tick();
      chk($sformatf("or fill%0d cnt", k), cnt1, k);
      chk($sformatf("or fill%0d empty_n", k), empty1, k >= 2);
      if (k >= 2) chk($sformatf("or fill%0d dout", k), dout1, 1);
    end
    w1 = 0;
    chk("or full full_n", full1, 0);
    chk("or full af_n", af1, 0);
    r1 = 1;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("or drain%0d dout", k), dout1, k);
      chk($sformatf("or drain%0d empty_n", k), empty1, 1);
      tick();
      if (k == 1) chk("or pop full_n", full1, 1);
      chk($sformatf("or drain%0d cnt", k), cnt1, 5 - k);
    end
    r1 = 0;
    chk("or drained empty_n", empty1, 0);

    // Steady push+pop at occupancy 2 on both variants.
    reset = 1; tick(); reset = 0;
    drive_both(1, 0, 8'd0); tick();
    drive_both(1, 0, 8'd1); tick();
    for (int k = 2; k < 22; k++) begin
      drive_both(1, 1, DW'(k));
      chk($sformatf("stream%0d dout0", k), dout0, k - 2);
      chk($sformatf("stream%0d dout1", k), dout1, k - 2);
      tick();
      chk($sformatf("stream%0d cnt0", k), cnt0, 2);
      chk($sformatf("stream%0d cnt1", k), cnt1, 2);
    end
    idle();

    // Reset in the middle of traffic with requests active.
    reset = 1; tick(); reset = 0;
    for (int k = 1; k <= 3; k++) begin
      drive_both(1, 0, DW'(k)); tick();
    end
    chk("mid cnt0", cnt0, 3);
    chk("mid cnt1", cnt1, 3);
    drive_both(1, 1, 8'hEE);
    reset = 1;
    tick();
    reset = 0;
    idle();
    chk("rstmid cnt0", cnt0, 0);
    chk("rstmid empty0", empty0, 0);
    chk("rstmid full0", full0, 1);
    chk("rstmid cnt1", cnt1, 0);
    chk("rstmid empty1", empty1, 0);
    chk("rstmid full1", full1, 1);
    chk("rstmid dout1", dout1, 0);
    drive_both(1, 0, 8'h07); tick();
    idle(); tick();
    chk("post dout0", dout0, 8'h07);
    chk("post dout1", dout1, 8'h07);
    chk("post empty1", empty1, 1);
    drive_both(0, 1, 8'h00); tick();
    idle();
    chk("post pop cnt0", cnt0, 0);
    chk("post pop cnt1", cnt1, 0);

    // Randomized traffic against a queue model.
    reset = 1; tick(); reset = 0;
    q0.delete(); q1.delete(); v1 = 0;
    for (int c = 0; c < 1500; c++) begin
      chk("rnd0 cnt", cnt0, q0.size());
      chk("rnd0 empty_n", empty0, q0.size() != 0);
      chk_flags("rnd0", 0, q0.size());
      if (q0.size() != 0) chk("rnd0 dout", dout0, q0[0]);
      srl = q1.size() - int'(v1);
      chk("rnd1 cnt", cnt1, q1.size());
      chk("rnd1 empty_n", empty1, v1);
      chk_flags("rnd1", 1, srl);
      if (v1) chk("rnd1 dout", dout1, q1[0]);

      // Alternate fill-biased and drain-biased phases to hit both boundaries.
      pct_w = ((c / 150) % 2 == 0) ? 75 : 35;
      pct_r = ((c / 150) % 2 == 0) ? 35 : 75;
      w0 = $urandom_range(99) < pct_w; wce0 = $urandom_range(7) != 0;
      r0 = $urandom_range(99) < pct_r; rce0 = $urandom_range(7) != 0;
      din0 = DW'($urandom);
      w1 = $urandom_range(99) < pct_w; wce1 = $urandom_range(7) != 0;
      r1 = $urandom_range(99) < pct_r; rce1 = $urandom_range(7) != 0;
      din1 = DW'($urandom);
      reset = $urandom_range(99) == 0;

      p0  = w0 && wce0 && (q0.size() != DEP);
      pp0 = r0 && rce0 && (q0.size() != 0);
      p1  = w1 && wce1 && (srl != DEP);
      pp1 = r1 && rce1 && v1;
      tick();
      if (reset) begin
        q0.delete(); q1.delete(); v1 = 0;
      end else begin
        if (pp0) void'(q0.pop_front());
        if (p0) q0.push_back(din0);
        // Output stage stays valid iff some word older than this cycle's write remains.
        old = q1.size() - int'(pp1);
        if (pp1) void'(q1.pop_front());
        if (p1) q1.push_back(din1);
        v1 = old > 0;
      end
    end
    reset = 0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
